// File: rtl/fpu64_pkg.sv
// fpu64_pkg: field layout, widths and divider FSM states shared by the FPU blocks.
// Format: sign [63], exponent [62:53] bias 511 (0 encodes zero), mantissa [52:0] with hidden 1.
package fpu64_pkg;
    localparam int EXP_W    = 10;
    localparam int MAN_W    = 53;
    localparam int BIAS     = 511;
    localparam int EXP_MAX  = 1023;
    localparam int SIGN_BIT = 63;
    localparam int EXP_HI   = 62;
    localparam int EXP_LO   = 53;
    localparam int MAN_HI   = 52;
    localparam int SIG_W    = MAN_W + 1;
    localparam int REM_W    = SIG_W + 1;
    typedef enum logic [1:0] {S_IDLE, S_ITER, S_NORM, S_DONE} div_state_t;
endpackage

// File: rtl/fpudiv64_step.sv
// fpudiv64_step: one combinational restoring-division step.
// Ports: i_rem/i_sig_b current remainder and divisor; o_rem next (shifted) remainder, o_q quotient bit.
module fpudiv64_step
    import fpu64_pkg::*;
(
    input  logic [REM_W-1:0] i_rem,
    input  logic [SIG_W-1:0] i_sig_b,
    output logic [REM_W-1:0] o_rem,
    output logic             o_q
);
    logic             w_ge;
    logic [REM_W-1:0] w_diff;
    assign w_ge   = i_rem >= {1'b0, i_sig_b};
    assign w_diff = w_ge ? i_rem - {1'b0, i_sig_b} : i_rem;
    // the remainder stays below sigB after a subtract, so the shift never loses a set bit
    assign o_rem  = w_diff << 1;
    assign o_q    = w_ge;
endmodule

// File: rtl/fpudiv64.sv
// fpudiv64: iterative radix-2 restoring divider for the FPU 64-bit format.
// Ports: clk, rst (async, active-high); in_valid/in_ready with A, B, rnd operand handshake;
//        out_valid/out_ready with registered res, dz, ovf, unf result handshake.
module fpudiv64
    import fpu64_pkg::*;
#(
    parameter int ITER = 56
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] A,
    input  logic [63:0] B,
    input  logic        rnd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] res,
    output logic        dz,
    output logic        ovf,
    output logic        unf
);
    localparam int CNT_W = $clog2(ITER);

    div_state_t       r_state, w_state_nxt;
    logic [REM_W-1:0] r_rem, w_rem_nxt;
    logic [SIG_W-1:0] r_sig_b;
    logic [ITER-1:0]  r_q;
    logic [CNT_W-1:0] r_cnt;
    logic [11:0]      r_exp;
    logic             r_sign, r_rnd, r_a_zero, r_b_zero;
    logic [63:0]      r_res;
    logic             r_dz, r_ovf, r_unf;
    logic             w_q_bit, w_accept, w_guard, w_special, w_big, w_small;
    logic             w_dz, w_ovf, w_unf, w_sat, w_zero;
    logic [11:0]      w_e_n, w_e_r;
    logic [MAN_W-1:0] w_frac_pre, w_frac;
    logic [MAN_W:0]   w_frac_inc;
    logic [EXP_W-1:0] w_exp;

    fpudiv64_step u_step (
        .i_rem   (r_rem),
        .i_sig_b (r_sig_b),
        .o_rem   (w_rem_nxt),
        .o_q     (w_q_bit)
    );

    assign in_ready  = r_state == S_IDLE;
    assign out_valid = r_state == S_DONE;
    assign res       = r_res;
    assign dz        = r_dz;
    assign ovf       = r_ovf;
    assign unf       = r_unf;
    assign w_accept  = in_valid && in_ready;

    // quotient lies in (1/2, 2): a clear MSB means one normalizing shift
    assign w_e_n      = r_q[ITER-1] ? r_exp : r_exp - 12'd1;
    assign w_frac_pre = r_q[ITER-1] ? r_q[ITER-2:2] : r_q[ITER-3:1];
    assign w_guard    = r_q[ITER-1] ? r_q[1] : r_q[0];
    assign w_frac_inc = {1'b0, w_frac_pre} + {{MAN_W{1'b0}}, r_rnd & w_guard};
    assign w_e_r      = w_e_n + {11'd0, w_frac_inc[MAN_W]};
    assign w_big      = $signed(w_e_r) >= 12'sd1024;
    assign w_small    = $signed(w_e_r) <= 12'sd0;
    assign w_special  = r_a_zero | r_b_zero;
    assign w_dz       = r_b_zero;
    assign w_ovf      = !w_special && w_big;
    assign w_unf      = !w_special && w_small;
    assign w_sat      = w_dz | w_ovf;
    assign w_zero     = r_a_zero | w_unf;
    assign w_exp      = w_sat ? EXP_W'(EXP_MAX) : w_zero ? '0 : w_e_r[EXP_W-1:0];
    assign w_frac     = w_sat ? '1 : w_zero ? '0 : w_frac_inc[MAN_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = in_valid ? S_ITER : S_IDLE;
            S_ITER:  w_state_nxt = (r_cnt == '0) ? S_NORM : S_ITER;
            S_NORM:  w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = out_ready ? S_IDLE : S_DONE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem    <= '0;
            r_sig_b  <= '0;
            r_q      <= '0;
            r_cnt    <= '0;
            r_exp    <= '0;
            r_sign   <= 1'b0;
            r_rnd    <= 1'b0;
            r_a_zero <= 1'b0;
            r_b_zero <= 1'b0;
            r_res    <= '0;
            r_dz     <= 1'b0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_rem    <= {2'b01, A[MAN_HI:0]};
                r_sig_b  <= {1'b1, B[MAN_HI:0]};
                r_q      <= '0;
                r_cnt    <= CNT_W'(ITER - 1);
                r_exp    <= {2'b00, A[EXP_HI:EXP_LO]} - {2'b00, B[EXP_HI:EXP_LO]} + 12'(BIAS);
                r_sign   <= A[SIGN_BIT] ^ B[SIGN_BIT];
                r_rnd    <= rnd;
                r_a_zero <= A[EXP_HI:EXP_LO] == '0;
                r_b_zero <= B[EXP_HI:EXP_LO] == '0;
            end
            if (r_state == S_ITER) begin
                r_rem <= w_rem_nxt;
                r_q   <= {r_q[ITER-2:0], w_q_bit};
                r_cnt <= r_cnt - 1'b1;
            end
            if (r_state == S_NORM) begin
                r_res <= {r_sign, w_exp, w_frac};
                r_dz  <= w_dz;
                r_ovf <= w_ovf;
                r_unf <= w_unf;
            end
            if (r_state == S_DONE && out_ready) begin
                r_dz  <= 1'b0;
                r_ovf <= 1'b0;
                r_unf <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fpudiv64.sv
// tb_fpudiv64: directed table-driven bench for fpudiv64 plus backpressure and reset sequences.
module tb_fpudiv64;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, rnd, out_valid, out_ready, dz, ovf, unf;
    logic [63:0] a, b, res;
    int          checks = 0;
    int          errors = 0;

    localparam logic [52:0] ONES = {53{1'b1}};
    localparam logic [52:0] H    = 53'h10000000000000;
    localparam logic [52:0] ALT  = 53'hAAAAAAAAAAAAA;
    localparam logic [52:0] ALT1 = 53'hAAAAAAAAAAAAB;

    typedef struct {
        logic [63:0] a, b;
        logic        rnd;
        logic [63:0] res;
        logic        dz, ovf, unf;
    } vec_t;

    fpudiv64 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (a),
        .B         (b),
        .rnd       (rnd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .dz        (dz),
        .ovf       (ovf),
        .unf       (unf)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] fp(input logic s, input logic [9:0] e, input logic [52:0] f);
        return {s, e, f};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic start_op(input logic [63:0] va, input logic [63:0] vb, input logic vr);
        int n = 0;
        @(negedge clk);
        a = va;
        b = vb;
        rnd = vr;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("accept_timeout", 64'(n), 64'd0);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // returns the index of the first post-accept edge at which out_valid is sampled high
    task automatic wait_done(output int lat);
        int n = 0;
        while (n < 200) begin
            @(negedge clk);
            if (out_valid) break;
            n++;
        end
        if (n >= 200) chk("done_timeout", 64'(n), 64'd0);
        lat = n + 1;
    endtask

    vec_t vt[17];

    initial begin
        int lat;
        logic [63:0] ra, rb;
        vt[0]  = '{fp(0,511,0),  fp(0,511,0),   0, fp(0,511,0),    0, 0, 0};
        vt[1]  = '{fp(0,511,0),  fp(0,512,H),   0, fp(0,509,ALT),  0, 0, 0};
        vt[2]  = '{fp(0,511,0),  fp(0,512,H),   1, fp(0,509,ALT1), 0, 0, 0};
        vt[3]  = '{fp(1,600,H),  fp(0,599,0),   0, fp(1,512,H),    0, 0, 0};
        vt[4]  = '{fp(0,1023,0), fp(0,1,0),     0, fp(0,1023,ONES),0, 1, 0};
        vt[5]  = '{fp(0,1,0),    fp(0,1023,0),  0, fp(0,0,0),      0, 0, 1};
        vt[6]  = '{fp(1,700,5),  fp(0,0,123),   0, fp(1,1023,ONES),1, 0, 0};
        vt[7]  = '{fp(0,0,0),    fp(1,0,0),     0, fp(1,1023,ONES),1, 0, 0};
        vt[8]  = '{fp(0,0,77),   fp(0,511,0),   0, fp(0,0,0),      0, 0, 0};
        vt[9]  = '{fp(1,0,0),    fp(0,300,9),   1, fp(1,0,0),      0, 0, 0};
        vt[10] = '{fp(0,1023,0), fp(0,511,0),   0, fp(0,1023,0),   0, 0, 0};
        vt[11] = '{fp(0,1023,0), fp(0,510,0),   0, fp(0,1023,ONES),0, 1, 0};
        vt[12] = '{fp(0,1,0),    fp(0,511,0),   0, fp(0,1,0),      0, 0, 0};
        vt[13] = '{fp(0,1,0),    fp(0,511,H),   0, fp(0,0,0),      0, 0, 1};
        vt[14] = '{fp(0,512,H),  fp(1,512,0),   0, fp(1,511,H),    0, 0, 0};
        vt[15] = '{fp(0,511,0),  fp(0,511,H),   1, fp(0,510,ALT1), 0, 0, 0};
        vt[16] = '{fp(1,511,0),  fp(1,511,H),   0, fp(0,510,ALT),  0, 0, 0};

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = '0;
        b = '0;
        rnd = 1'b0;
        #12;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_res", res, 64'd0);
        chk("rst_flags", 64'({dz, ovf, unf}), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            start_op(vt[i].a, vt[i].b, vt[i].rnd);
            wait_done(lat);
            chk($sformatf("v%0d_latency", i), 64'(lat), 64'd58);
            chk($sformatf("v%0d_res", i), res, vt[i].res);
            chk($sformatf("v%0d_flags", i), 64'({dz, ovf, unf}), 64'({vt[i].dz, vt[i].ovf, vt[i].unf}));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_in_ready_after", i), 64'(in_ready), 64'd1);
            chk($sformatf("v%0d_flags_cleared", i), 64'({out_valid, dz, ovf, unf}), 64'd0);
        end

        // backpressure: result held, new operands ignored
        out_ready = 1'b0;
        start_op(fp(0,1023,0), fp(0,1,0), 0);
        wait_done(lat);
        chk("bp_latency", 64'(lat), 64'd58);
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            a = fp(0,600,0);
            b = fp(0,0,0);
            @(negedge clk);
            chk($sformatf("bp%0d_res", k), res, fp(0,1023,ONES));
            chk($sformatf("bp%0d_flags", k), 64'({dz, ovf, unf}), 64'b010);
            chk($sformatf("bp%0d_hs", k), 64'({out_valid, in_ready}), 64'b10);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release", 64'({out_valid, in_ready}), 64'b01);

        // back-to-back ops complete in order
        start_op(vt[3].a, vt[3].b, vt[3].rnd);
        wait_done(lat);
        ra = res;
        start_op(vt[2].a, vt[2].b, vt[2].rnd);
        wait_done(lat);
        rb = res;
        chk("b2b_first", ra, vt[3].res);
        chk("b2b_second", rb, vt[2].res);
        chk("b2b_latency", 64'(lat), 64'd58);

        // asynchronous reset in the middle of the iteration
        start_op(fp(0,511,0), fp(0,512,H), 1);
        repeat (19) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_res", res, 64'd0);
        chk("midrst_flags", 64'({dz, ovf, unf}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        start_op(fp(0,511,0), fp(0,511,0), 0);
        wait_done(lat);
        chk("postrst_latency", 64'(lat), 64'd58);
        chk("postrst_res", res, fp(0,511,0));
        chk("postrst_flags", 64'({dz, ovf, unf}), 64'd0);
        @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
